// File: rtl/drum_audio_out_pkg.sv
// Shared types and fixed-point constants for the drum membrane audio output path.
// Amplitudes are signed 1.17; scaling runs in a 25-bit domain so a shift of 7 cannot overflow.
package drum_audio_out_pkg;

  localparam int AMP_W    = 18;
  localparam int AMP_FRAC = 17;
  localparam int SHIFT_W  = 3;
  localparam int EXT_W    = AMP_W + (1 << SHIFT_W) - 1;

  localparam logic signed [EXT_W-1:0] SAT_MAX = 25'sd131071;
  localparam logic signed [EXT_W-1:0] SAT_MIN = -25'sd131072;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SCALE = 2'd2
  } drum_state_e;

  // Gain and clamp back into the 1.17 range.
  function automatic logic [AMP_W-1:0] scale_sat(input logic [AMP_W-1:0] a,
                                                 input logic [SHIFT_W-1:0] sh);
    logic signed [EXT_W-1:0] x;
    x = $signed({{(EXT_W-AMP_W){a[AMP_W-1]}}, a}) <<< sh;
    if (x > SAT_MAX)      return SAT_MAX[AMP_W-1:0];
    else if (x < SAT_MIN) return SAT_MIN[AMP_W-1:0];
    else                  return x[AMP_W-1:0];
  endfunction

endpackage

// File: rtl/drum_sample_fifo.sv
// Power-of-two circular sample buffer; pointers wrap by natural overflow.
module drum_sample_fifo #(
  parameter int DEPTH = 4,
  parameter int OUT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [OUT_W-1:0]         din,
  output logic [OUT_W-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: the top masks the head while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/drum_audio_out.sv
// Requests node-grid steps, scales the returned center amplitude and buffers it for the DAC.
// One step outstanding at most, so a push never meets a full buffer.
module drum_audio_out
  import drum_audio_out_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OUT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  output logic                   step_req,
  input  logic                   amp_valid,
  input  logic [17:0]            amp_in,
  input  logic [2:0]             gain_shift,
  output logic                   dac_valid,
  input  logic                   dac_ready,
  output logic [OUT_W-1:0]       dac_left,
  output logic [OUT_W-1:0]       dac_right,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   spurious
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [1:0]       rst_sync;
  logic             rst_n;
  drum_state_e      state;
  logic [AMP_W-1:0] amp_q;
  logic [2:0]       shift_q;
  logic [AMP_W-1:0] sat;
  logic [OUT_W-1:0] din, head;
  logic             push, pop, can_step;

  // Assert asynchronously, release two edges later in clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign dac_valid = (fifo_level != '0);
  assign pop       = dac_valid & dac_ready;
  assign push      = (state == ST_SCALE);
  assign can_step  = run && ((fifo_level < FULL) || pop);
  assign sat       = scale_sat(amp_q, shift_q);
  assign din       = sat[AMP_W-1 -: OUT_W];
  assign dac_left  = dac_valid ? head : '0;
  assign dac_right = dac_valid ? head : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      step_req <= 1'b0;
      amp_q    <= '0;
      shift_q  <= '0;
      spurious <= 1'b0;
    end else begin
      step_req <= 1'b0;
      case (state)
        ST_IDLE: if (can_step) begin
          step_req <= 1'b1;
          state    <= ST_WAIT;
        end
        // run is deliberately ignored here: an issued step always completes.
        ST_WAIT: if (amp_valid) begin
          amp_q   <= amp_in;
          shift_q <= gain_shift;
          state   <= ST_SCALE;
        end
        ST_SCALE: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
      if (amp_valid && state != ST_WAIT) spurious <= 1'b1;
    end
  end

  drum_sample_fifo #(.DEPTH(DEPTH), .OUT_W(OUT_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_drum_audio_out.sv
// Self-checking bench for drum_audio_out: directed scenarios plus a randomized grid/DAC run.
module tb_drum_audio_out;

  localparam int DEPTH = 4;
  localparam int OUT_W = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset, run, amp_valid, dac_ready;
  logic [17:0]      amp_in;
  logic [2:0]       gain_shift;
  logic             step_req, dac_valid, spurious;
  logic [OUT_W-1:0] dac_left, dac_right;
  logic [LW-1:0]    fifo_level;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  drum_audio_out #(.DEPTH(DEPTH), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .step_req   (step_req),
    .amp_valid  (amp_valid),
    .amp_in     (amp_in),
    .gain_shift (gain_shift),
    .dac_valid  (dac_valid),
    .dac_ready  (dac_ready),
    .dac_left   (dac_left),
    .dac_right  (dac_right),
    .fifo_level (fifo_level),
    .spurious   (spurious)
  );

  // Reference: real-valued gain, clamp to 1.17 range, keep the top 16 bits.
  function automatic logic [15:0] ref_sample(input logic [17:0] a, input logic [2:0] sh);
    longint v;
    logic [17:0] s;
    v = longint'($signed(a)) * (longint'(1) << sh);
    if (v > 131071)       v = 131071;
    else if (v < -131072) v = -131072;
    s = v[17:0];
    return s[17:2];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Wait for a step request, answer it, and drop run once the step is in flight.
  task automatic serve(input logic [17:0] a, input logic [2:0] sh);
    bit ok;
    ok  = 0;
    run = 1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (step_req) ok = 1;
      else tick();
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL step_req_timeout: got none, required one within 40 cycles");
    end
    amp_in = a; gain_shift = sh; amp_valid = 1; run = 0;
    tick();
    amp_valid = 0;
  endtask

  task automatic test_reset();
    reset = 1; run = 0; amp_valid = 0; dac_ready = 0; amp_in = '0; gain_shift = '0;
    #2 reset = 0;
    #1;
    n_cmp++; if (step_req !== 1'b0)  begin n_err++; $display("FAIL rst_step_req: got %b want 0", step_req); end
    n_cmp++; if (dac_valid !== 1'b0) begin n_err++; $display("FAIL rst_dac_valid: got %b want 0", dac_valid); end
    n_cmp++; if (fifo_level !== '0)  begin n_err++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
    n_cmp++; if (dac_left !== '0 || dac_right !== '0)
      begin n_err++; $display("FAIL rst_data: got %h/%h want 0/0", dac_left, dac_right); end
    n_cmp++; if (spurious !== 1'b0)  begin n_err++; $display("FAIL rst_spurious: got %b want 0", spurious); end
    repeat (3) tick();
    reset = 1; run = 1;
    tick();
    n_cmp++; if (step_req !== 1'b0)  begin n_err++; $display("FAIL rst_release_early_step: got %b want 0", step_req); end
    run = 0;
    repeat (3) tick();
  endtask

  task automatic test_spurious();
    amp_in = 18'h01234; amp_valid = 1;
    tick();
    amp_valid = 0;
    n_cmp++; if (spurious !== 1'b1)  begin n_err++; $display("FAIL spur_flag: got %b want 1", spurious); end
    n_cmp++; if (fifo_level !== '0)  begin n_err++; $display("FAIL spur_level: got %0d want 0", fifo_level); end
    repeat (4) tick();
    n_cmp++; if (dac_valid !== 1'b0 || fifo_level !== '0 || step_req !== 1'b0)
      begin n_err++; $display("FAIL spur_idle: got valid=%b level=%0d step=%b want 0/0/0", dac_valid, fifo_level, step_req); end
    n_cmp++; if (spurious !== 1'b1)  begin n_err++; $display("FAIL spur_sticky: got %b want 1", spurious); end
  endtask

  task automatic test_basic();
    dac_ready = 1;
    serve(18'h04000, 3'd0);
    n_cmp++; if (dac_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b want 0", dac_valid); end
    tick();
    n_cmp++; if (dac_valid !== 1'b1 || dac_left !== 16'h1000 || dac_right !== 16'h1000)
      begin n_err++; $display("FAIL basic_sample: got v=%b %h/%h want 1 1000/1000", dac_valid, dac_left, dac_right); end
    tick();
    n_cmp++; if (dac_valid !== 1'b0) begin n_err++; $display("FAIL basic_pop: got %b want 0", dac_valid); end
  endtask

  task automatic test_saturation();
    dac_ready = 1;
    serve(18'h10000, 3'd3);
    tick();
    n_cmp++; if (dac_valid !== 1'b1 || dac_left !== 16'h7FFF || dac_right !== 16'h7FFF)
      begin n_err++; $display("FAIL sat_pos: got v=%b %h/%h want 1 7fff", dac_valid, dac_left, dac_right); end
    serve(18'h30000, 3'd3);
    tick();
    n_cmp++; if (dac_valid !== 1'b1 || dac_left !== 16'h8000 || dac_right !== 16'h8000)
      begin n_err++; $display("FAIL sat_neg: got v=%b %h/%h want 1 8000", dac_valid, dac_left, dac_right); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [17:0] a [4];
    logic [2:0]  s [4];
    logic [15:0] e;
    bit saw;
    dac_ready = 0;
    for (int k = 0; k < 4; k++) begin
      a[k] = 18'($urandom);
      s[k] = 3'($urandom_range(0, 2));
      serve(a[k], s[k]);
    end
    tick();
    n_cmp++; if (fifo_level !== LW'(4)) begin n_err++; $display("FAIL bp_full: got %0d want 4", fifo_level); end
    run = 1; saw = 0;
    for (int i = 0; i < 8; i++) begin
      if (step_req) saw = 1;
      tick();
    end
    n_cmp++; if (saw !== 1'b0) begin n_err++; $display("FAIL bp_step_when_full: got step, want none"); end
    n_cmp++; if (dac_left !== ref_sample(a[0], s[0]))
      begin n_err++; $display("FAIL bp_hold: got %h want %h", dac_left, ref_sample(a[0], s[0])); end
    dac_ready = 1;
    for (int i = 0; i < 4; i++) begin
      if (step_req) begin saw = 1; run = 0; end
      e = ref_sample(a[i], s[i]);
      n_cmp++; if (dac_valid !== 1'b1 || dac_left !== e || dac_right !== e)
        begin n_err++; $display("FAIL bp_order[%0d]: got v=%b %h/%h want 1 %h", i, dac_valid, dac_left, dac_right, e); end
      tick();
    end
    if (step_req) saw = 1;
    run = 0;
    n_cmp++; if (saw !== 1'b1) begin n_err++; $display("FAIL bp_step_resume: got none, want step_req"); end
    n_cmp++; if (fifo_level !== '0) begin n_err++; $display("FAIL bp_drain: got %0d want 0", fifo_level); end
    amp_in = 18'h0ABCD; gain_shift = 3'd1; amp_valid = 1;
    tick();
    amp_valid = 0;
    tick();
    e = ref_sample(18'h0ABCD, 3'd1);
    n_cmp++; if (dac_valid !== 1'b1 || dac_left !== e)
      begin n_err++; $display("FAIL bp_resumed_sample: got v=%b %h want 1 %h", dac_valid, dac_left, e); end
    tick();
  endtask

  task automatic test_random();
    logic [15:0] q [$];
    logic [15:0] e;
    bit pend;
    bit done;
    int wait_cnt;
    pend = 0; done = 0; wait_cnt = 0;
    run = 1;
    for (int c = 0; c < 700 && !done; c++) begin
      if (c >= 300) run = 0;
      dac_ready = (c >= 300) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (dac_valid && dac_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rnd_extra: got %h, want no sample", dac_left);
        end else begin
          e = q.pop_front();
          if (dac_left !== e || dac_right !== e)
            begin n_err++; $display("FAIL rnd_data: got %h/%h want %h", dac_left, dac_right, e); end
        end
      end
      amp_valid = 0;
      if (step_req && !pend) begin pend = 1; wait_cnt = $urandom_range(0, 3); end
      if (pend) begin
        if (wait_cnt == 0) begin
          amp_in = 18'($urandom); gain_shift = 3'($urandom);
          amp_valid = 1;
          q.push_back(ref_sample(amp_in, gain_shift));
          pend = 0;
        end else wait_cnt--;
      end
      if (c > 300 && !pend && !amp_valid && q.size() == 0 && fifo_level == '0) done = 1;
      tick();
    end
    amp_valid = 0;
    n_cmp++; if (!done || q.size() != 0 || fifo_level !== '0)
      begin n_err++; $display("FAIL rnd_drain: got left=%0d level=%0d, want 0/0", q.size(), fifo_level); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [15:0] e;
    dac_ready = 0;
    serve(18'h02000, 3'd0);
    serve(18'h3F000, 3'd2);
    tick();
    run = 1; ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (step_req) ok = 1;
      else tick();
    end
    n_cmp++; if (!ok || fifo_level !== LW'(2))
      begin n_err++; $display("FAIL mid_setup: got step=%b level=%0d want 1/2", ok, fifo_level); end
    #2 reset = 0;
    #1;
    n_cmp++; if (dac_valid !== 1'b0 || fifo_level !== '0 || step_req !== 1'b0)
      begin n_err++; $display("FAIL mid_rst_ctl: got v=%b lvl=%0d step=%b want 0", dac_valid, fifo_level, step_req); end
    n_cmp++; if (dac_left !== '0 || dac_right !== '0 || spurious !== 1'b0)
      begin n_err++; $display("FAIL mid_rst_data: got %h/%h spur=%b want 0", dac_left, dac_right, spurious); end
    @(posedge clk); #1;
    reset = 1;
    tick();
    n_cmp++; if (step_req !== 1'b0) begin n_err++; $display("FAIL mid_release_early_step: got %b want 0", step_req); end
    dac_ready = 1;
    serve(18'h05555, 3'd1);
    tick();
    e = ref_sample(18'h05555, 3'd1);
    n_cmp++; if (dac_valid !== 1'b1 || dac_left !== e || fifo_level !== LW'(1))
      begin n_err++; $display("FAIL mid_resume: got v=%b %h lvl=%0d want 1 %h 1", dac_valid, dac_left, fifo_level, e); end
    tick();
  endtask

  initial begin
    test_reset();
    test_spurious();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/drum_audio_out.md
DRUM_AUDIO_OUT -- requirements
Module: drum_audio_out

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, sample FIFO depth (power of two, 2..16).
REQ-002 The module SHALL have parameter OUT_W, default 16, audio sample width.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset  input  1  asynchronous, active-low reset: asserts immediately when low, releases synchronously with clk.
REQ-005 The module SHALL have port run  input  1  enable for requesting new simulation steps.
REQ-006 The module SHALL have port step_req  output  1  one-cycle pulse asking the node grid to advance one time step.
REQ-007 The module SHALL have port amp_valid  input  1  one-cycle strobe: the grid finished a step and amp_in is valid.
REQ-008 The module SHALL have port amp_in  input  18  signed center-node amplitude, 1.17 fixed point.
REQ-009 The module SHALL have port gain_shift  input  3  arithmetic left-shift amount (0..7), sampled on capture.
REQ-010 The module SHALL have port dac_valid  output  1  the sample on dac_left/dac_right is valid.
REQ-011 The module SHALL have port dac_ready  input  1  the audio core accepts the sample this cycle.
REQ-012 The module SHALL have ports dac_left and dac_right  output  OUT_W  signed audio sample; both carry the same value.
REQ-013 The module SHALL have port fifo_level  output  clog2(DEPTH)+1  number of occupied FIFO entries.
REQ-014 The module SHALL have port spurious  output  1  sticky flag: amp_valid was received while not in WAIT.

Function
REQ-015 The control FSM SHALL have states IDLE, WAIT and SCALE.
REQ-016 In IDLE with run=1 and (fifo_level < DEPTH, or fifo_level = DEPTH with a pop this cycle), the FSM SHALL pulse step_req for one cycle and go to WAIT; otherwise it SHALL stay in IDLE.
REQ-017 In WAIT, on amp_valid the FSM SHALL capture amp_in and gain_shift and go to SCALE; otherwise it SHALL stay in WAIT, with no timeout.
REQ-018 In SCALE the FSM SHALL push one sample and return to IDLE.
REQ-019 At most one step SHALL be outstanding, so a push in SCALE can never find the FIFO full.
REQ-020 Scaling SHALL sign-extend amp_in to 25 bits, shift it left by gain_shift, saturate it to [-2^17, 2^17-1], and output bits [17:18-OUT_W] of the saturated value.
REQ-021 Latency SHALL be: amp_valid at cycle N, push at N+1, dac_valid high at N+2 when the FIFO was empty.
REQ-022 dac_valid SHALL be 1 whenever fifo_level > 0, and the data outputs SHALL present the FIFO head.
REQ-023 A pop SHALL occur when dac_valid and dac_ready are both 1.
REQ-024 Data SHALL be stable while dac_valid=1 and dac_ready=0.
REQ-025 Simultaneous push and pop SHALL leave fifo_level unchanged and keep the data order.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH.
REQ-027 amp_valid in IDLE or SCALE SHALL be ignored for data and SHALL set spurious, which holds until reset.
REQ-028 Deasserting run in WAIT SHALL NOT abort the step: the sample is still captured and pushed.

Reset
REQ-029 While reset=0: FSM in IDLE, FIFO empty, step_req=0, dac_valid=0, dac_left=dac_right=0, fifo_level=0, spurious=0.
REQ-030 Reset asserted mid-operation (any state, FIFO non-empty) SHALL discard all in-flight and buffered samples.
REQ-031 The first step_req after reset release SHALL occur no earlier than the second rising clk edge after release.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, AMP_W=18, the 1.17 format constants and the saturation bounds.
REQ-033 The FIFO SHALL be one sub-module, drum_sample_fifo (parameters DEPTH and OUT_W; ports push, pop, din, dout, level), instantiated once.

Verification
REQ-034 Scenario: run=1, gain_shift=0, amp_in=18'h04000 -> dac_left=dac_right=16'h1000, with dac_valid two cycles after amp_valid.
REQ-035 Scenario: gain_shift=3, amp_in=18'h10000 -> 16'h7FFF; amp_in=18'h30000 -> 16'h8000 (saturation both signs).
REQ-036 Scenario: dac_ready=0 with four steps served -> fifo_level=4 and no further step_req; then dac_ready=1 -> one pop per cycle with order preserved and step_req resuming.
REQ-037 Scenario: amp_valid pulsed in IDLE with run=0 -> spurious=1, fifo_level stays 0, dac_valid stays 0.
REQ-038 Scenario: reset low for one cycle while in WAIT with fifo_level=2 -> all outputs 0 immediately; after release, normal request/capture resumes.
